// File: rtl/imem_fetch_responder_pkg.sv
// rtl/imem_fetch_responder_pkg.sv - shared types and constants for the instruction fetch responder
package imem_fetch_responder_pkg;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0000_3000;
  localparam logic [31:0] NOP_INSTR         = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] instr;
    logic        fault;
  } rsp_t;

  localparam int RSP_W = $bits(rsp_t);

  // Limit is computed in 33 bits so a window ending at 4 GiB cannot wrap.
  function automatic logic fetch_fault(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input int          depth_words);
    logic [32:0] limit;
    limit = {1'b0, base} + (33'(depth_words) << 2);
    return (addr < base) || ({1'b0, addr} >= limit) || (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/imem_fetch_responder_rsp_fifo.sv
// rtl/imem_fetch_responder_rsp_fifo.sv - in-order response buffer with clear
module imem_fetch_responder_rsp_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] slots [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] fill;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty   = (fill == '0);
  assign do_push = push && (fill < CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign head    = slots[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      if (do_push && !do_pop)      fill <= fill + CNT_W'(1);
      else if (!do_push && do_pop) fill <= fill - CNT_W'(1);
    end
  end

  // Storage carries no reset; the fill count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push && !clear) slots[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/imem_fetch_responder.sv
// rtl/imem_fetch_responder.sv - instruction memory answering fetch requests with fixed latency and credits
module imem_fetch_responder
  import imem_fetch_responder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int          DEPTH_WORDS = 4096,
  parameter int          LATENCY     = 2,
  parameter int          BUF_DEPTH   = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           req_valid,
  input  logic [31:0]                    req_addr,
  output logic                           req_ready,
  input  logic                           flush,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [31:0]                    rsp_addr,
  output logic [31:0]                    rsp_instr,
  output logic                           rsp_fault,
  input  logic                           load_en,
  input  logic [$clog2(DEPTH_WORDS)-1:0] load_idx,
  input  logic [31:0]                    load_data
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);

  logic [31:0]        imem [DEPTH_WORDS];
  logic [CNT_W-1:0]   count;
  logic               accept;
  logic               pop;
  logic               fifo_empty;
  logic [IDX_W-1:0]   lookup_idx;
  rsp_t               lookup_rsp;
  logic [LATENCY-1:0] pipe_valid;
  rsp_t               pipe_data [LATENCY];
  rsp_t               fifo_head;
  rsp_t               last_head;
  rsp_t               shown;

  // count covers in-flight plus buffered work, so a credit is never overcommitted.
  assign req_ready = !flush && (count < CNT_W'(BUF_DEPTH));
  assign accept    = req_valid && req_ready;
  assign rsp_valid = !fifo_empty;
  assign pop       = rsp_valid && rsp_ready;

  always_comb begin
    lookup_idx       = IDX_W'((req_addr - BASE_ADDR) >> 2);
    lookup_rsp.addr  = req_addr;
    lookup_rsp.fault = fetch_fault(req_addr, BASE_ADDR, DEPTH_WORDS);
    lookup_rsp.instr = lookup_rsp.fault ? NOP_INSTR : imem[lookup_idx];
  end

  // Write lands at the edge, so a same-edge lookup still captures the old word.
  always_ff @(posedge clk) begin
    if (load_en) imem[load_idx] <= load_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pipe_valid <= '0;
      for (int i = 0; i < LATENCY; i++) pipe_data[i] <= '0;
    end else begin
      pipe_valid[0] <= accept;
      pipe_data[0]  <= lookup_rsp;
      for (int i = 1; i < LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1] && !flush;
        pipe_data[i]  <= pipe_data[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else if (accept && !pop) begin
      count <= count + CNT_W'(1);
    end else if (!accept && pop) begin
      count <= count - CNT_W'(1);
    end
  end

  imem_fetch_responder_rsp_fifo #(
    .WIDTH (RSP_W),
    .DEPTH (BUF_DEPTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (flush),
    .push      (pipe_valid[LATENCY-1]),
    .push_data (pipe_data[LATENCY-1]),
    .pop       (pop),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  // Remember the last head shown so outputs hold steady while the buffer is empty.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_head <= '0;
    end else if (!fifo_empty) begin
      last_head <= fifo_head;
    end
  end

  assign shown     = fifo_empty ? last_head : fifo_head;
  assign rsp_addr  = shown.addr;
  assign rsp_instr = shown.instr;
  assign rsp_fault = shown.fault;

endmodule

// File: tb/tb_imem_fetch_responder.sv
// tb/tb_imem_fetch_responder.sv - directed table-driven bench for the fetch responder
module tb_imem_fetch_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready;
  logic        flush;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_addr;
  logic [31:0] rsp_instr;
  logic        rsp_fault;
  logic        load_en;
  logic [11:0] load_idx;
  logic [31:0] load_data;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  imem_fetch_responder #(
    .BASE_ADDR   (32'h0000_3000),
    .DEPTH_WORDS (4096),
    .LATENCY     (2),
    .BUF_DEPTH   (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .flush     (flush),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_addr  (rsp_addr),
    .rsp_instr (rsp_instr),
    .rsp_fault (rsp_fault),
    .load_en   (load_en),
    .load_idx  (load_idx),
    .load_data (load_data)
  );

  typedef struct packed {
    logic        req_valid;
    logic [31:0] req_addr;
    logic        rsp_rdy;
    logic        flush;
    logic        ld_en;
    logic [31:0] ld_data;
    logic        exp_ready;
    logic        exp_valid;
    logic        chk_data;
    logic [31:0] exp_addr;
    logic [31:0] exp_instr;
  } cyc_vec_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        exp_fault;
    logic [31:0] exp_instr;
  } fetch_vec_t;

  cyc_vec_t   seq [12];
  fetch_vec_t fv  [9];

  function automatic cyc_vec_t cv(input logic rv, input logic [31:0] ra, input logic rr,
                                  input logic fl, input logic le, input logic [31:0] ld,
                                  input logic er, input logic ev, input logic cd,
                                  input logic [31:0] ea, input logic [31:0] ei);
    cyc_vec_t v;
    v = '{rv, ra, rr, fl, le, ld, er, ev, cd, ea, ei};
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [11:0] idx, input logic [31:0] data);
    load_en   = 1'b1;
    load_idx  = idx;
    load_data = data;
    tick();
    load_en = 1'b0;
  endtask

  task automatic flush_pulse();
    req_valid = 1'b0;
    flush     = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  // Each row: drive after an edge, check at the following falling edge.
  task automatic run_seq(input string tag, input int n);
    for (int c = 0; c < n; c++) begin
      req_valid = seq[c].req_valid;
      req_addr  = seq[c].req_addr;
      rsp_ready = seq[c].rsp_rdy;
      flush     = seq[c].flush;
      load_en   = seq[c].ld_en;
      load_idx  = '0;
      load_data = seq[c].ld_data;
      @(negedge clk);
      chk($sformatf("%s c%0d req_ready", tag, c), 32'(req_ready), 32'(seq[c].exp_ready));
      chk($sformatf("%s c%0d rsp_valid", tag, c), 32'(rsp_valid), 32'(seq[c].exp_valid));
      if (seq[c].chk_data) begin
        chk($sformatf("%s c%0d rsp_addr", tag, c), rsp_addr, seq[c].exp_addr);
        chk($sformatf("%s c%0d rsp_instr", tag, c), rsp_instr, seq[c].exp_instr);
      end
      tick();
    end
    req_valid = 1'b0;
    flush     = 1'b0;
    load_en   = 1'b0;
    rsp_ready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset     = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    flush     = 1'b0;
    rsp_ready = 1'b1;
    load_en   = 1'b0;
    load_idx  = '0;
    load_data = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset req_ready", 32'(req_ready), 32'd1);
    chk("reset rsp_addr", rsp_addr, 32'h0);
    chk("reset rsp_instr", rsp_instr, 32'h0);
    chk("reset rsp_fault", 32'(rsp_fault), 32'd0);
    tick();
    reset = 1'b1;
    tick();

    load_word(12'd0, 32'h1111_1111);
    load_word(12'd1, 32'h2222_2222);
    load_word(12'd2, 32'h3333_3333);
    load_word(12'd3, 32'h4444_4444);
    load_word(12'd4, 32'h5555_5555);
    load_word(12'd4095, 32'hCAFE_F00D);

    // Back-to-back fetches; third one waits for a credit.
    seq[0] = cv(1, 32'h3000, 1, 0, 0, 0, 1, 0, 0, 0, 0);
    seq[1] = cv(1, 32'h3004, 1, 0, 0, 0, 1, 0, 0, 0, 0);
    seq[2] = cv(1, 32'h3008, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    seq[3] = cv(1, 32'h3008, 1, 0, 0, 0, 0, 1, 1, 32'h3000, 32'h1111_1111);
    seq[4] = cv(1, 32'h3008, 1, 0, 0, 0, 1, 1, 1, 32'h3004, 32'h2222_2222);
    seq[5] = cv(0, 32'h0,    1, 0, 0, 0, 1, 0, 1, 32'h3004, 32'h2222_2222);
    seq[6] = cv(0, 32'h0,    1, 0, 0, 0, 1, 0, 0, 0, 0);
    seq[7] = cv(0, 32'h0,    1, 0, 0, 0, 1, 1, 1, 32'h3008, 32'h3333_3333);
    seq[8] = cv(0, 32'h0,    1, 0, 0, 0, 1, 0, 1, 32'h3008, 32'h3333_3333);
    run_seq("stream", 9);
    flush_pulse();

    fv[0] = '{32'h0000_3000, 1'b0, 32'h1111_1111};
    fv[1] = '{32'h0000_300C, 1'b0, 32'h4444_4444};
    fv[2] = '{32'h0000_6FFC, 1'b0, 32'hCAFE_F00D};
    fv[3] = '{32'h0000_2FFC, 1'b1, 32'h0};
    fv[4] = '{32'h0000_3002, 1'b1, 32'h0};
    fv[5] = '{32'h0000_7000, 1'b1, 32'h0};
    fv[6] = '{32'h0000_0000, 1'b1, 32'h0};
    fv[7] = '{32'hFFFF_FFFC, 1'b1, 32'h0};
    fv[8] = '{32'h0000_3001, 1'b1, 32'h0};
    for (int i = 0; i < 9; i++) begin
      req_valid = 1'b1;
      req_addr  = fv[i].addr;
      @(negedge clk);
      chk($sformatf("fv%0d req_ready", i), 32'(req_ready), 32'd1);
      tick();
      req_valid = 1'b0;
      @(negedge clk);
      chk($sformatf("fv%0d early1", i), 32'(rsp_valid), 32'd0);
      tick();
      @(negedge clk);
      chk($sformatf("fv%0d early2", i), 32'(rsp_valid), 32'd0);
      tick();
      @(negedge clk);
      chk($sformatf("fv%0d rsp_valid", i), 32'(rsp_valid), 32'd1);
      chk($sformatf("fv%0d rsp_addr", i), rsp_addr, fv[i].addr);
      chk($sformatf("fv%0d rsp_instr", i), rsp_instr, fv[i].exp_instr);
      chk($sformatf("fv%0d rsp_fault", i), 32'(rsp_fault), 32'(fv[i].exp_fault));
      tick();
    end
    flush_pulse();

    // Backpressure: two credits, then release the consumer.
    seq[0] = cv(1, 32'h3000, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    seq[1] = cv(1, 32'h3004, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    seq[2] = cv(1, 32'h3008, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    seq[3] = cv(1, 32'h3008, 0, 0, 0, 0, 0, 1, 1, 32'h3000, 32'h1111_1111);
    seq[4] = cv(1, 32'h3008, 0, 0, 0, 0, 0, 1, 1, 32'h3000, 32'h1111_1111);
    seq[5] = cv(1, 32'h3008, 0, 0, 0, 0, 0, 1, 1, 32'h3000, 32'h1111_1111);
    seq[6] = cv(1, 32'h3008, 1, 0, 0, 0, 0, 1, 1, 32'h3000, 32'h1111_1111);
    seq[7] = cv(0, 32'h0,    1, 0, 0, 0, 1, 1, 1, 32'h3004, 32'h2222_2222);
    seq[8] = cv(0, 32'h0,    1, 0, 0, 0, 1, 0, 1, 32'h3004, 32'h2222_2222);
    run_seq("bp", 9);
    flush_pulse();

    // Flush with two in flight and a competing request.
    seq[0] = cv(1, 32'h3000, 1, 0, 0, 0, 1, 0, 0, 0, 0);
    seq[1] = cv(1, 32'h3004, 1, 0, 0, 0, 1, 0, 0, 0, 0);
    seq[2] = cv(1, 32'h3010, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    seq[3] = cv(1, 32'h3010, 1, 0, 0, 0, 1, 0, 0, 0, 0);
    seq[4] = cv(0, 32'h0,    1, 0, 0, 0, 1, 0, 0, 0, 0);
    seq[5] = cv(0, 32'h0,    1, 0, 0, 0, 1, 0, 0, 0, 0);
    seq[6] = cv(0, 32'h0,    1, 0, 0, 0, 1, 1, 1, 32'h3010, 32'h5555_5555);
    seq[7] = cv(0, 32'h0,    1, 0, 0, 0, 1, 0, 1, 32'h3010, 32'h5555_5555);
    run_seq("flush", 8);
    flush_pulse();

    // Load at the same edge as a fetch of that word.
    seq[0] = cv(1, 32'h3000, 1, 0, 1, 32'hDEAD_BEEF, 1, 0, 0, 0, 0);
    seq[1] = cv(1, 32'h3000, 1, 0, 0, 0, 1, 0, 0, 0, 0);
    seq[2] = cv(0, 32'h0,    1, 0, 0, 0, 0, 0, 0, 0, 0);
    seq[3] = cv(0, 32'h0,    1, 0, 0, 0, 0, 1, 1, 32'h3000, 32'h1111_1111);
    seq[4] = cv(0, 32'h0,    1, 0, 0, 0, 1, 1, 1, 32'h3000, 32'hDEAD_BEEF);
    seq[5] = cv(0, 32'h0,    1, 0, 0, 0, 1, 0, 1, 32'h3000, 32'hDEAD_BEEF);
    run_seq("load", 6);
    flush_pulse();

    // Asynchronous reset with a full buffer.
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_addr  = 32'h3004;
    repeat (4) tick();
    req_valid = 1'b0;
    @(negedge clk);
    chk("arst pre rsp_valid", 32'(rsp_valid), 32'd1);
    chk("arst pre req_ready", 32'(req_ready), 32'd0);
    #2;
    reset = 1'b0;
    #1;
    chk("arst rsp_valid", 32'(rsp_valid), 32'd0);
    chk("arst rsp_addr", rsp_addr, 32'h0);
    chk("arst rsp_instr", rsp_instr, 32'h0);
    @(negedge clk);
    #2;
    reset     = 1'b1;
    rsp_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk($sformatf("arst post c%0d rsp_valid", c), 32'(rsp_valid), 32'd0);
      chk($sformatf("arst post c%0d req_ready", c), 32'(req_ready), 32'd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/imem_fetch_responder.md
Name: imem_fetch_responder

Overview:
- Instruction-memory responder for the fetch stage. The fetch unit issues PC requests; this block answers each one with the instruction word.
- It has a configurable read latency, a bounded response buffer with credit-based backpressure, and flush-on-redirect for branch, jump and jr.
- It sits between the fetch unit and the F/D pipeline register. It also has a load port so a bench or bootloader can fill the program.

Parameters:
- BASE_ADDR, 32'h00003000, byte address of instruction word 0.
- DEPTH_WORDS, 4096, number of 32-bit words stored.
- LATENCY, 2, cycles from request acceptance to the response entering the buffer. Legal range is 1..3.
- BUF_DEPTH, 2, maximum outstanding requests (in flight plus buffered). Legal range is 2..4.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  fetch request present.
- req_addr  in  32  byte address (the PC) of the request.
- req_ready  out  1  request can be accepted this cycle.
- flush  in  1  redirect; discard all outstanding work.
- rsp_valid  out  1  response at the buffer head.
- rsp_ready  in  1  consumer takes the head this cycle.
- rsp_addr  out  32  address of the head response.
- rsp_instr  out  32  instruction word of the head response.
- rsp_fault  out  1  head response was an illegal fetch.
- load_en  in  1  write a program word.
- load_idx  in  log2(DEPTH_WORDS)  word index to write.
- load_data  in  32  word to write.

Behaviour:
- Reset (asynchronous, active low):
  - Clears pipeline valids, buffer pointers and the outstanding count.
  - Outputs: rsp_valid=0, rsp_addr=0, rsp_instr=0, rsp_fault=0, req_ready=1.
  - Memory contents are not reset.
- Accept: a request is accepted when req_valid && req_ready && !flush.
  - req_ready = !flush && (count < BUF_DEPTH).
  - count is a registered value. req_ready never depends combinationally on rsp_ready.
- Lookup, performed at acceptance:
  - Fault if req_addr < BASE_ADDR, or req_addr >= BASE_ADDR + 4*DEPTH_WORDS, or req_addr[1:0] != 0.
  - On fault: rsp_instr = 32'h0 (nop) and rsp_fault = 1.
  - Otherwise: index = (req_addr - BASE_ADDR) >> 2.
- Latency:
  - A request accepted at edge k enters a LATENCY-stage valid/addr/data shift pipeline.
  - It is written into the response buffer at edge k+LATENCY.
  - With the buffer empty, rsp_valid rises after edge k+LATENCY.
  - One acceptance per cycle gives full throughput while rsp_ready=1 and BUF_DEPTH >= LATENCY+1. Otherwise throughput is limited by credits.
- Response buffer:
  - In-order FIFO of BUF_DEPTH entries holding {addr, instr, fault}.
  - rsp_* show the head entry. The head is popped when rsp_valid && rsp_ready.
  - While rsp_valid=0, rsp_addr, rsp_instr and rsp_fault hold their last values (0 after reset).
  - Push and pop may happen in the same cycle. The buffer never overflows, because credits bound total occupancy.
- count update:
  - +1 on accept, -1 on pop, unchanged when both occur in the same cycle.
  - count <= BUF_DEPTH always holds.
- Flush (synchronous, sampled at the clock edge):
  - Clears all pipeline valids, empties the buffer and sets count=0.
  - A request presented in the flush cycle is not accepted (req_ready=0).
  - A pop in the flush cycle is irrelevant; the buffer is empty afterwards.
  - A new request is accepted in the next cycle.
- Load port:
  - Synchronous write at the edge when load_en=1.
  - Requests accepted at a later edge see the new data.
  - A request accepted at the same edge reads the old data.
  - Loading an index while the same word is in flight does not alter the in-flight data.
- Reset asserted mid-operation drops everything immediately. No response is produced after reset deasserts unless a new request is accepted.

Decomposition:
- Shared package holds:
  - BASE_ADDR default.
  - NOP_INSTR = 32'h0.
  - The response struct/field widths {addr[31:0], instr[31:0], fault}.
- One natural sub-module: rsp_fifo, a generic synchronous FIFO with BUF_DEPTH entries, asynchronous active-low reset and a flush (clear) input, instantiated for the response buffer.

Test Plan:
- Reset, then load words 0..3 with 32'h11111111..32'h44444444, LATENCY=2, rsp_ready=1, requests at 0x3000, 0x3004, 0x3008 on consecutive cycles -> responses appear 2 cycles after each acceptance, in order, with matching addr/instr and fault=0.
- rsp_ready=0 with continuous req_valid, BUF_DEPTH=2 -> exactly 2 accepts, then req_ready=0. Raise rsp_ready -> head 0x3000 pops, and req_ready returns 1 the next cycle.
- Requests at 0x2FFC, 0x3002 and 0x3000+4*DEPTH_WORDS -> each responds with rsp_fault=1, rsp_instr=0, and rsp_addr equal to the request address.
- Two requests in flight, flush asserted together with a new req at 0x3010 -> req_ready=0 that cycle, no response for any of them. A next-cycle req at 0x3010 is answered normally.
- load_en writes idx 0 = 32'hDEADBEEF at the same edge a request for 0x3000 is accepted -> that response returns the old word; a following request returns 32'hDEADBEEF.
- reset pulsed low asynchronously (mid-cycle) while the buffer is full -> rsp_valid=0 immediately, req_ready=1 after release, no stale responses appear.
